// File: rtl/lc_dist_pipe.sv
// Pipelined cell-index to {line, column} converter with pair distance and range flag.
// Three stages (capture, divide, distance) share one global advance enable.
module lc_dist_pipe #(
   parameter int LINES     = 9,
   parameter int COLS      = 9,
   parameter int DIST_MODE = 0,
   parameter int TAG_W     = 8,
   localparam int CELLS    = LINES * COLS,
   localparam int CELL_W   = (CELLS > 1) ? $clog2(CELLS) : 1,
   localparam int L_W      = (LINES > 1) ? $clog2(LINES) : 1,
   localparam int C_W      = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int DIST_W   = (LINES + COLS - 1 > 1) ? $clog2(LINES + COLS - 1) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [CELL_W-1:0]  in_c1,
   input  logic [CELL_W-1:0]  in_c2,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [L_W+C_W-1:0] out_lc1,
   output logic [L_W+C_W-1:0] out_lc2,
   output logic [DIST_W-1:0]  out_dist,
   output logic               out_err,
   output logic [TAG_W-1:0]   out_tag
);

   // CELLS can be an exact power of two, so the bound needs one extra bit.
   localparam logic [CELL_W:0]   CELLS_V = (CELL_W + 1)'(CELLS);
   localparam logic [CELL_W-1:0] COLS_V  = CELL_W'(COLS);

   logic en;

   logic              s1_valid;
   logic [CELL_W-1:0] s1_c1;
   logic [CELL_W-1:0] s1_c2;
   logic              s1_err;
   logic [TAG_W-1:0]  s1_tag;

   logic              s2_valid;
   logic [L_W-1:0]    s2_l1;
   logic [C_W-1:0]    s2_k1;
   logic [L_W-1:0]    s2_l2;
   logic [C_W-1:0]    s2_k2;
   logic              s2_err;
   logic [TAG_W-1:0]  s2_tag;

   logic [CELL_W-1:0] q1, r1, q2, r2;
   logic [L_W-1:0]    dl;
   logic [C_W-1:0]    dc;
   logic [DIST_W-1:0] dl_w, dc_w, dist_nxt;

   assign en       = !out_valid || out_ready;
   assign in_ready = en && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_c1    <= '0;
         s1_c2    <= '0;
         s1_err   <= 1'b0;
         s1_tag   <= '0;
      end else if (en) begin
         s1_valid <= in_valid;
         s1_c1    <= in_c1;
         s1_c2    <= in_c2;
         s1_err   <= ({1'b0, in_c1} >= CELLS_V) || ({1'b0, in_c2} >= CELLS_V);
         s1_tag   <= in_tag;
      end
   end

   // Constant divisor: synthesis reduces this to a fixed divider network.
   always_comb begin
      q1 = s1_c1 / COLS_V;
      r1 = s1_c1 % COLS_V;
      q2 = s1_c2 / COLS_V;
      r2 = s1_c2 % COLS_V;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_l1    <= '0;
         s2_k1    <= '0;
         s2_l2    <= '0;
         s2_k2    <= '0;
         s2_err   <= 1'b0;
         s2_tag   <= '0;
      end else if (en) begin
         s2_valid <= s1_valid;
         s2_l1    <= s1_err ? '0 : L_W'(q1);
         s2_k1    <= s1_err ? '0 : C_W'(r1);
         s2_l2    <= s1_err ? '0 : L_W'(q2);
         s2_k2    <= s1_err ? '0 : C_W'(r2);
         s2_err   <= s1_err;
         s2_tag   <= s1_tag;
      end
   end

   // Zeroed coordinates on error make the distance zero as well.
   always_comb begin
      dl       = (s2_l1 > s2_l2) ? (s2_l1 - s2_l2) : (s2_l2 - s2_l1);
      dc       = (s2_k1 > s2_k2) ? (s2_k1 - s2_k2) : (s2_k2 - s2_k1);
      dl_w     = DIST_W'(dl);
      dc_w     = DIST_W'(dc);
      dist_nxt = dl_w + dc_w;
      if (DIST_MODE != 0) begin
         dist_nxt = (dl_w > dc_w) ? dl_w : dc_w;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_lc1   <= '0;
         out_lc2   <= '0;
         out_dist  <= '0;
         out_err   <= 1'b0;
         out_tag   <= '0;
      end else if (en) begin
         out_valid <= s2_valid;
         out_lc1   <= {s2_l1, s2_k1};
         out_lc2   <= {s2_l2, s2_k2};
         out_dist  <= dist_nxt;
         out_err   <= s2_err;
         out_tag   <= s2_tag;
      end
   end

endmodule

// File: tb/tb_lc_dist_pipe.sv
// Bench for lc_dist_pipe: 9x9 Manhattan and Chebyshev instances share stimulus,
// a 4x6 instance covers the non-square grid.
module tb_lc_dist_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // shared 9x9 stimulus
   logic       in_valid = 1'b0;
   logic [6:0] in_c1 = '0, in_c2 = '0;
   logic [7:0] in_tag = '0;
   logic       out_ready = 1'b1;

   logic       ir_m, ov_m, err_m, ir_c, ov_c, err_c;
   logic [7:0] lc1_m, lc2_m, tag_m, lc1_c, lc2_c, tag_c;
   logic [4:0] dist_m, dist_c;

   // 4x6 stimulus
   logic       iv_s = 1'b0;
   logic [4:0] c1_s = '0, c2_s = '0;
   logic [7:0] tg_s = '0;
   logic       or_s = 1'b1;
   logic       ir_s, ov_s, err_s;
   logic [4:0] lc1_s, lc2_s;
   logic [3:0] dist_s;
   logic [7:0] tag_s;

   lc_dist_pipe #(.LINES(9), .COLS(9), .DIST_MODE(0), .TAG_W(8)) u_man (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_m),
      .in_c1(in_c1), .in_c2(in_c2), .in_tag(in_tag),
      .out_valid(ov_m), .out_ready(out_ready), .out_lc1(lc1_m), .out_lc2(lc2_m),
      .out_dist(dist_m), .out_err(err_m), .out_tag(tag_m));

   lc_dist_pipe #(.LINES(9), .COLS(9), .DIST_MODE(1), .TAG_W(8)) u_cheb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_c),
      .in_c1(in_c1), .in_c2(in_c2), .in_tag(in_tag),
      .out_valid(ov_c), .out_ready(out_ready), .out_lc1(lc1_c), .out_lc2(lc2_c),
      .out_dist(dist_c), .out_err(err_c), .out_tag(tag_c));

   lc_dist_pipe #(.LINES(4), .COLS(6), .DIST_MODE(0), .TAG_W(8)) u_rect (
      .clk(clk), .rst(rst), .in_valid(iv_s), .in_ready(ir_s),
      .in_c1(c1_s), .in_c2(c2_s), .in_tag(tg_s),
      .out_valid(ov_s), .out_ready(or_s), .out_lc1(lc1_s), .out_lc2(lc2_s),
      .out_dist(dist_s), .out_err(err_s), .out_tag(tag_s));

   int n_tot = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      int lc1, lc2, dm, dc, err, tag;
   } exp_t;

   exp_t sb[$];

   // line of a cell by repeated subtraction of whole rows
   function automatic int line_of(int c, int cols);
      int l = 0;
      while (c >= cols) begin
         c -= cols;
         l++;
      end
      return l;
   endfunction

   function automatic int absd(int a, int b);
      return (a > b) ? a - b : b - a;
   endfunction

   function automatic exp_t model(int a, int b, int t, int lines, int cols, int cw);
      exp_t e;
      int la, ka, lb, kb;
      e.tag = t;
      if (a >= lines * cols || b >= lines * cols) begin
         e.err = 1; e.lc1 = 0; e.lc2 = 0; e.dm = 0; e.dc = 0;
      end else begin
         la = line_of(a, cols); ka = a - la * cols;
         lb = line_of(b, cols); kb = b - lb * cols;
         e.err = 0;
         e.lc1 = la * (1 << cw) + ka;
         e.lc2 = lb * (1 << cw) + kb;
         e.dm  = absd(la, lb) + absd(ka, kb);
         e.dc  = (absd(la, lb) > absd(ka, kb)) ? absd(la, lb) : absd(ka, kb);
      end
      return e;
   endfunction

   // one pair through the 9x9 instances; returns edges until out_valid
   task automatic send_one(input int a, input int b, input int t, output int lat);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_c1 = 7'(a); in_c2 = 7'(b); in_tag = 8'(t);
      #1;
      chk("in_ready_accept", 32'(ir_m), 1);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!ov_m && lat < 10) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic check_9x9(input string nm, input exp_t e);
      chk({nm, "_valid"}, 32'(ov_m), 1);
      chk({nm, "_lc1"},  32'(lc1_m), e.lc1);
      chk({nm, "_lc2"},  32'(lc2_m), e.lc2);
      chk({nm, "_dm"},   32'(dist_m), e.dm);
      chk({nm, "_dc"},   32'(dist_c), e.dc);
      chk({nm, "_err"},  32'(err_m), e.err);
      chk({nm, "_tag"},  32'(tag_m), e.tag);
      chk({nm, "_errc"}, 32'(err_c), e.err);
   endtask

   initial begin
      int lat, acc, k, j, a, b;
      exp_t e;

      // reset state
      #1;
      chk("rst_out_valid", 32'(ov_m), 0);
      chk("rst_in_ready", 32'(ir_m), 0);
      chk("rst_dist", 32'(dist_m), 0);
      chk("rst_tag", 32'(tag_m), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(ir_m), 1);
      @(negedge clk);

      // directed 9x9 pairs
      send_one(0, 80, 8'h5A, lat);
      chk("lat_0_80", lat, 3);
      e = '{lc1: 8'h00, lc2: 8'h88, dm: 16, dc: 8, err: 0, tag: 8'h5A};
      check_9x9("p0_80", e);
      @(negedge clk);

      send_one(10, 35, 8'h21, lat);
      chk("lat_10_35", lat, 3);
      e = '{lc1: 8'h11, lc2: 8'h38, dm: 9, dc: 7, err: 0, tag: 8'h21};
      check_9x9("p10_35", e);
      @(negedge clk);

      send_one(81, 5, 8'h33, lat);
      e = '{lc1: 0, lc2: 0, dm: 0, dc: 0, err: 1, tag: 8'h33};
      check_9x9("oor81", e);
      @(negedge clk);

      send_one(127, 0, 8'h44, lat);
      e = '{lc1: 0, lc2: 0, dm: 0, dc: 0, err: 1, tag: 8'h44};
      check_9x9("oor127", e);
      @(negedge clk);

      // backpressure: fill with tags 1..5 while the consumer is stalled
      out_ready = 1'b0;
      acc = 0;
      k = 1;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_c1 = 7'(k); in_c2 = 7'(k); in_tag = 8'(k);
         #1;
         if (ir_m) begin
            acc++;
            k++;
         end
         @(negedge clk);
      end
      chk("bp_accepts", acc, 3);
      #1;
      chk("bp_in_ready", 32'(ir_m), 0);
      chk("bp_out_valid", 32'(ov_m), 1);
      chk("bp_held_tag", 32'(tag_m), 1);
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         in_valid = (k <= 5);
         in_c1 = 7'(k); in_c2 = 7'(k); in_tag = 8'(k);
         #1;
         if (in_valid && ir_m) k++;
         chk("bp_drain_valid", 32'(ov_m), 1);
         chk("bp_drain_tag", 32'(tag_m), i);
         @(negedge clk);
      end
      in_valid = 1'b0;
      #1;
      chk("bp_empty", 32'(ov_m), 0);
      @(negedge clk);

      // reset with three pairs in flight
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_c1 = 7'(i); in_c2 = 7'(i + 9); in_tag = 8'(8'hE0 + i);
         @(negedge clk);
      end
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 32'(ov_m), 0);
      chk("mid_rst_in_ready", 32'(ir_m), 0);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("no_stale", 32'(ov_m), 0);
         @(negedge clk);
      end
      send_one(40, 0, 8'h77, lat);
      chk("lat_after_rst", lat, 3);
      e = model(40, 0, 8'h77, 9, 9, 4);
      check_9x9("after_rst", e);
      @(negedge clk);

      // 4x6 grid: directed pair then exhaustive sweep
      or_s = 1'b1;
      iv_s = 1'b1; c1_s = 5'd23; c2_s = 5'd6; tg_s = 8'h66;
      @(negedge clk);
      iv_s = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("r_valid", 32'(ov_s), 1);
      chk("r_lc1", 32'(lc1_s), 29);
      chk("r_lc2", 32'(lc2_s), 8);
      chk("r_dist", 32'(dist_s), 7);
      chk("r_tag", 32'(tag_s), 8'h66);
      @(negedge clk);
      j = 0;
      for (int i = 0; i < 30; i++) begin
         iv_s = (i < 24);
         c1_s = 5'(i); c2_s = 5'((23 - i) & 31); tg_s = 8'(i);
         #1;
         if (ov_s) begin
            e = model(j, 23 - j, j, 4, 6, 3);
            chk("sweep_lc1", 32'(lc1_s), e.lc1);
            chk("sweep_lc2", 32'(lc2_s), e.lc2);
            chk("sweep_dist", 32'(dist_s), e.dm);
            chk("sweep_err", 32'(err_s), 0);
            chk("sweep_tag", 32'(tag_s), j);
            j++;
         end
         @(negedge clk);
      end
      chk("sweep_count", j, 24);

      // randomized traffic on the 9x9 pair against the queue model
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         a = $urandom_range(0, 90);
         b = $urandom_range(0, 90);
         in_c1 = 7'(a); in_c2 = 7'(b); in_tag = 8'($urandom_range(0, 255));
         #1;
         chk("rnd_ready_eq", 32'(ir_c), 32'(ir_m));
         if (ov_m && out_ready) begin
            if (sb.size() == 0) begin
               chk("rnd_spurious", 32'(ov_m), 0);
            end else begin
               e = sb.pop_front();
               check_9x9("rnd", e);
               chk("rnd_valid_c", 32'(ov_c), 1);
            end
         end
         if (in_valid && ir_m) sb.push_back(model(a, b, in_tag, 9, 9, 4));
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (ov_m) begin
            if (sb.size() == 0) begin
               chk("drain_spurious", 32'(ov_m), 0);
            end else begin
               e = sb.pop_front();
               check_9x9("drain", e);
            end
         end
         @(negedge clk);
      end
      chk("sb_left", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
